// File: rtl/scan_sequencer.sv
// Scan sequencer: steps a registered 3-bit index (i2,i1,i0) up or down from a
// start index to a terminal index, holding each index for a programmable dwell.
// Optional build macro SCAN_SEQ_WRAP_EN: when defined, the scan reloads its
// start index after the terminal step and never asserts done.
module scan_sequencer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic [2:0]         last,
  input  logic [DWELL_W-1:0] dwell,
  output logic               i2,
  output logic               i1,
  output logic               i0,
  output logic               busy,
  output logic               step,
  output logic               done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [DWELL_W-1:0] CNT_ONE = 1;

  logic [1:0]         state;
  logic [2:0]         idx;
  logic [DWELL_W-1:0] dwell_cnt;
  logic               dir_q;
  logic [2:0]         last_q;
  logic [DWELL_W-1:0] dwell_q;

  logic [2:0]         term_idx;
  logic [2:0]         start_idx;
  logic               dwell_end;

  // Terminal/start indices and end-of-dwell, derived only from registered state
  always_comb begin
    term_idx  = dir_q ? 3'd0 : last_q;
    start_idx = dir_q ? last_q : 3'd0;
    dwell_end = (dwell_cnt == dwell_q);
  end

  // Scan state machine; every output is a register updated here
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 3'd0;
      dwell_cnt <= '0;
      dir_q     <= 1'b0;
      last_q    <= 3'd0;
      dwell_q   <= '0;
      busy      <= 1'b0;
      step      <= 1'b0;
      done      <= 1'b0;
    end else begin
      step <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            dir_q     <= dir;
            last_q    <= last;
            dwell_q   <= dwell;
            idx       <= dir ? last : 3'd0;
            dwell_cnt <= '0;
            step      <= 1'b1;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state     <= IDLE;
            idx       <= 3'd0;
            dwell_cnt <= '0;
            busy      <= 1'b0;
          end else if (dwell_end) begin
            dwell_cnt <= '0;
            if (idx == term_idx) begin
`ifdef SCAN_SEQ_WRAP_EN
              idx  <= start_idx;
              step <= 1'b1;
`else
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
`endif
            end else begin
              idx  <= dir_q ? (idx - 3'd1) : (idx + 3'd1);
              step <= 1'b1;
            end
          end else begin
            dwell_cnt <= dwell_cnt + CNT_ONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          idx   <= 3'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign i2 = idx[2];
  assign i1 = idx[1];
  assign i0 = idx[0];

  // start_idx only feeds the wrap path; keep it referenced in the default build
  logic unused_ok;
  assign unused_ok = ^start_idx;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed testbench for scan_sequencer with hand-computed expected values.
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       dir;
  logic [2:0] last;
  logic [3:0] dwell;
  logic       i2, i1, i0;
  logic       busy, step, done;

  int vectors = 0;
  int miscompares = 0;

  scan_sequencer #(.DWELL_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir),
    .last(last), .dwell(dwell), .i2(i2), .i1(i1), .i0(i0),
    .busy(busy), .step(step), .done(done)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic d, input logic [2:0] l, input logic [3:0] w);
    start = s;
    dir   = d;
    last  = l;
    dwell = w;
  endtask

  // Checks index, strobes and the one-hot decoder image of the index
  task automatic checkState(input string tag, input int eIdx, input logic eStep,
                            input logic eBusy, input logic eDone);
    logic [2:0] eI;
    logic [7:0] dec;
    logic [7:0] eDec;
    eI   = eIdx[2:0];
    dec  = 8'd1 << {i2, i1, i0};
    eDec = 8'd1 << eI;
    checkOutput({tag, ".idx"},  {5'd0, i2, i1, i0}, {5'd0, eI});
    checkOutput({tag, ".step"}, {7'd0, step}, {7'd0, eStep});
    checkOutput({tag, ".busy"}, {7'd0, busy}, {7'd0, eBusy});
    checkOutput({tag, ".done"}, {7'd0, done}, {7'd0, eDone});
    checkOutput({tag, ".dec"},  dec, eDec);
  endtask

  // Behaviour after the terminal step of a scan
  task automatic checkEnd(input string tag, input int term, input int startIdx);
`ifdef SCAN_SEQ_WRAP_EN
    checkState({tag, ".wrap"}, startIdx, 1'b1, 1'b1, 1'b0);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    checkState({tag, ".wrapstop"}, 0, 1'b0, 1'b0, 1'b0);
`else
    checkState({tag, ".done"}, term, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    tick;
    start = 1'b0;
    checkState({tag, ".idle"}, term, 1'b0, 1'b0, 1'b0);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    checkState({tag, ".idlestop"}, term, 1'b0, 1'b0, 1'b0);
    if (startIdx < 0) $display("[TB] unexpected start index");
`endif
  endtask

  initial begin
    rst  = 1'b1;
    stop = 1'b0;
    applyStimulus(1'b1, 1'b0, 3'd5, 4'd3);
    tick;
    tick;
    checkState("reset", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0, 4'd0);
    tick;
    checkState("postreset", 0, 1'b0, 1'b0, 1'b0);

    // Up-count, last=3, dwell=1; inputs scrambled while busy
    applyStimulus(1'b1, 1'b0, 3'd3, 4'd1);
    tick;
    applyStimulus(1'b0, 1'b1, 3'd7, 4'd15);
    for (int i = 0; i < 8; i++) begin
      checkState("up", i / 2, (i % 2) == 0, 1'b1, 1'b0);
      tick;
    end
    checkEnd("up", 3, 0);

    // Down-count, last=7, dwell=0
    applyStimulus(1'b1, 1'b1, 3'd7, 4'd0);
    tick;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkState("down", 7 - i, 1'b1, 1'b1, 1'b0);
      tick;
    end
    checkEnd("down", 0, 7);

    // Stop on the fourth RUN cycle, last=5, dwell=2
    applyStimulus(1'b1, 1'b0, 3'd5, 4'd2);
    tick;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkState("dwell", 0, i == 0, 1'b1, 1'b0);
      tick;
    end
    checkState("dwell4", 1, 1'b1, 1'b1, 1'b0);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    checkState("stop", 0, 1'b0, 1'b0, 1'b0);
    tick;
    checkState("stopidle", 0, 1'b0, 1'b0, 1'b0);

    // Stop wins over terminal completion in the same cycle
    applyStimulus(1'b1, 1'b0, 3'd0, 4'd0);
    tick;
    start = 1'b0;
    checkState("term0", 0, 1'b1, 1'b1, 1'b0);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    checkState("stopterm", 0, 1'b0, 1'b0, 1'b0);

    // Start ignored during RUN, then reset mid-scan at index 4
    applyStimulus(1'b1, 1'b0, 3'd7, 4'd0);
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkState("run", i, 1'b1, 1'b1, 1'b0);
      if (i == 2) start = 1'b1;
      tick;
      start = 1'b0;
    end
    checkState("run4", 4, 1'b1, 1'b1, 1'b0);
    rst   = 1'b1;
    start = 1'b1;
    tick;
    rst   = 1'b0;
    start = 1'b0;
    checkState("midrst", 0, 1'b0, 1'b0, 1'b0);

    // First edge after reset with start begins a normal scan
    applyStimulus(1'b1, 1'b1, 3'd2, 4'd0);
    tick;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkState("restart", 2 - i, 1'b1, 1'b1, 1'b0);
      tick;
    end
    checkEnd("restart", 0, 2);

    // Single-step scan, last=0, both directions
    applyStimulus(1'b1, 1'b1, 3'd0, 4'd0);
    tick;
    start = 1'b0;
    checkState("one", 0, 1'b1, 1'b1, 1'b0);
    tick;
    checkEnd("one", 0, 0);
    applyStimulus(1'b1, 1'b0, 3'd0, 4'd0);
    tick;
    start = 1'b0;
    checkState("oneup", 0, 1'b1, 1'b1, 1'b0);
    tick;
    checkEnd("oneup", 0, 0);

`ifdef SCAN_SEQ_WRAP_EN
    // Continuous wrap, last=2, dwell=0
    applyStimulus(1'b1, 1'b0, 3'd2, 4'd0);
    tick;
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checkState("wraploop", i % 3, 1'b1, 1'b1, 1'b0);
      tick;
    end
    stop = 1'b1;
    tick;
    stop = 1'b0;
    checkState("wraploopstop", 0, 1'b0, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter DWELL_W, default 4, width of the per-step dwell count.
REQ-002 clk  input  1  rising-edge clock; only clock in the block.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a scan; sampled only in IDLE.
REQ-005 stop  input  1  abort the scan in progress.
REQ-006 dir  input  1  0 = count up, 1 = count down; latched at start.
REQ-007 last  input  3  terminal index; latched at start.
REQ-008 dwell  input  DWELL_W  cycles per step minus one; latched at start.
REQ-009 i2, i1, i0  output  1 each  registered 3-bit scan index, MSB i2, drives the downstream 3-to-8 decoder inputs directly.
REQ-010 busy  output  1  high while in RUN.
REQ-011 step  output  1  one-cycle pulse on the first cycle each new index is presented.
REQ-012 done  output  1  one-cycle pulse on scan completion.

Function
REQ-013 The block SHALL implement exactly three states: IDLE, RUN, DONE; all outputs registered, no combinational input-to-output paths.
REQ-014 IDLE with start=1: next edge enters RUN, latches dir/last/dwell, loads index 0 (dir=0) or last (dir=1), clears dwell counter, asserts step and busy.
REQ-015 RUN: each index SHALL be held for dwell_q+1 cycles, dwell counter counting 0..dwell_q.
REQ-016 RUN, counter==dwell_q, index not terminal: next edge advances index by +1 (dir=0) or -1 (dir=1), clears counter, pulses step.
REQ-017 Terminal index is last_q when dir=0 and 0 when dir=1.
REQ-018 RUN, counter==dwell_q, index terminal: behaviour per REQ-027/REQ-028.
REQ-019 Indices SHALL stay within 0..last_q for dir=0; arithmetic is 3-bit, and no wrap past 7 or below 0 SHALL ever occur.
REQ-020 last=0 SHALL give a single-step scan at index 0 (either dir).
REQ-021 stop=1 in RUN: next edge enters IDLE, index 000, busy 0, no done pulse; stop has priority over step completion on the same cycle.
REQ-022 start in RUN or DONE SHALL be ignored; stop in IDLE or DONE SHALL be ignored.
REQ-023 DONE lasts exactly one cycle: done=1, busy=0, index holds terminal value; then IDLE, index unchanged until next start.
REQ-024 Changes to dir/last/dwell while busy SHALL have no effect.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, {i2,i1,i0}=000, busy=0, step=0, done=0, dwell counter 0, latched fields 0; rst overrides start/stop and applies mid-scan.
REQ-026 First edge with rst=0 and start=1 SHALL start a scan normally.

Configuration
REQ-027 Macro SCAN_SEQ_WRAP_EN undefined: terminal step completion enters DONE (one-pass scan).
REQ-028 SCAN_SEQ_WRAP_EN defined: terminal step completion reloads the start index (0 or last_q), pulses step, stays in RUN; done never asserts; scan ends only via stop or rst.

Verification
REQ-029 rst, then start with dir=0, last=3, dwell=1 -> index 0,0,1,1,2,2,3,3 on consecutive cycles, step on each first cycle, done one cycle after last 3, busy low in that cycle.
REQ-030 start with dir=1, last=7, dwell=0 -> index 7,6,5,4,3,2,1,0 one per cycle, 8 step pulses, then done=1 for exactly one cycle.
REQ-031 start last=5, dwell=2, stop raised on the 4th RUN cycle -> next cycle IDLE, index 000, busy 0, done never asserts.
REQ-032 rst asserted mid-scan at index 4 -> next cycle all outputs zero; start pulse during RUN causes no restart.
REQ-033 last=0, dwell=0 -> one step at index 0, done next cycle; with SCAN_SEQ_WRAP_EN, last=2, dwell=0, dir=0 -> 0,1,2,0,1,2... with step every cycle, done stays 0.
REQ-034 Every cycle: decoder driven by {i2,i1,i0} shows exactly one active output, matching the index.
